// File: rtl/seg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : seg_arbiter
//  Description : Round-robin arbiter sharing the 16-bit seven-segment display
//                value among NREQ requesters. A winner's value is latched and
//                held for HOLD_CYCLES cycles, then the winner gets a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_arbiter #(
    parameter int NREQ        = 2,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*16-1:0]        req_data,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic [15:0]               data_seg,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int OWN_W = $clog2(NREQ);

    // Counter load value: the gnt cycle itself is the first of the hold cycles.
    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [OWN_W-1:0] C_LAST_REQ  = OWN_W'(NREQ - 1);
    // With a one-cycle hold, done must coincide with gnt.
    localparam logic             C_ONE_CYCLE = (HOLD_CYCLES == 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q,  state_d;
    logic [OWN_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [OWN_W-1:0]  owner_q,  owner_d;
    logic              busy_q,   busy_d;
    logic [15:0]       data_q,   data_d;
    logic [NREQ-1:0]   gnt_q,    gnt_d;
    logic [NREQ-1:0]   done_q,   done_d;

    logic              found_w;
    logic [OWN_W-1:0]  sel_w;

    // Round-robin pick: first asserted request at or above rr_ptr, wrapping.
    always_comb begin
        found_w = 1'b0;
        sel_w   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_w && req[(int'(rr_ptr_q) + i) % NREQ]) begin
                found_w = 1'b1;
                sel_w   = OWN_W'((int'(rr_ptr_q) + i) % NREQ);
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/HOLD controller.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        data_d   = data_q;
        gnt_d    = '0;
        done_d   = '0;
        case (state_q)
            IDLE: begin
                if (found_w) begin
                    data_d        = req_data[16*int'(sel_w) +: 16];
                    gnt_d[sel_w]  = 1'b1;
                    done_d[sel_w] = C_ONE_CYCLE;
                    owner_d       = sel_w;
                    busy_d        = 1'b1;
                    cnt_d         = C_HOLD_LOAD;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    // done is registered, so raise it on the edge where cnt reaches 0.
                    if (cnt_q == CNT_W'(1)) begin
                        done_d[owner_q] = 1'b1;
                    end
                end else begin
                    rr_ptr_d = (owner_q == C_LAST_REQ) ? '0 : owner_q + 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; a reset mid-hold discards the value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            owner_q  <= '0;
            busy_q   <= 1'b0;
            data_q   <= 16'h0000;
            gnt_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign data_seg = data_q;
    assign busy     = busy_q;
    assign owner    = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_arbiter
//  Description : Directed self-checking bench for seg_arbiter, one instance
//                with a 4-cycle hold and one with a 1-cycle hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  req4 = 2'b00;
    logic [31:0] rdat4 = 32'h0;
    logic [1:0]  gnt4, done4;
    logic [15:0] seg4;
    logic        busy4;
    logic [0:0]  own4;

    logic [1:0]  req1 = 2'b00;
    logic [31:0] rdat1 = 32'h0;
    logic [1:0]  gnt1, done1;
    logic [15:0] seg1;
    logic        busy1;
    logic [0:0]  own1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg_arbiter #(.NREQ(2), .HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .req_data(rdat4),
        .gnt(gnt4), .done(done4), .data_seg(seg4), .busy(busy4), .owner(own4)
    );

    seg_arbiter #(.NREQ(2), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .req_data(rdat1),
        .gnt(gnt1), .done(done1), .data_seg(seg1), .busy(busy1), .owner(own1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full output snapshot of the HOLD_CYCLES=4 instance.
    task automatic chk4(input string tag, input logic [1:0] g, input logic [1:0] d,
                        input logic [15:0] s, input logic b, input logic o);
        chk({tag, ".gnt"},   {14'h0, gnt4},  {14'h0, g});
        chk({tag, ".done"},  {14'h0, done4}, {14'h0, d});
        chk({tag, ".seg"},   seg4,           s);
        chk({tag, ".busy"},  {15'h0, busy4}, {15'h0, b});
        chk({tag, ".owner"}, {15'h0, own4},  {15'h0, o});
    endtask

    task automatic chk1(input string tag, input logic [1:0] g, input logic [1:0] d,
                        input logic [15:0] s, input logic b, input logic o);
        chk({tag, ".gnt"},   {14'h0, gnt1},  {14'h0, g});
        chk({tag, ".done"},  {14'h0, done1}, {14'h0, d});
        chk({tag, ".seg"},   seg1,           s);
        chk({tag, ".busy"},  {15'h0, busy1}, {15'h0, b});
        chk({tag, ".owner"}, {15'h0, own1},  {15'h0, o});
    endtask

    initial begin
        // Reset for two cycles, then idle with no requests.
        step();
        step();
        rst = 1'b0;
        step();
        chk4("rst_a", 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
        chk1("rst1_a", 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        chk4("rst_b", 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);

        // Single request from requester 0.
        req4  = 2'b01;
        rdat4 = {16'h0000, 16'h1234};
        step();
        chk4("single_k1", 2'b01, 2'b00, 16'h1234, 1'b1, 1'b0);
        req4 = 2'b00;
        step();
        chk4("single_k2", 2'b00, 2'b00, 16'h1234, 1'b1, 1'b0);
        step();
        chk4("single_k3", 2'b00, 2'b00, 16'h1234, 1'b1, 1'b0);
        step();
        chk4("single_k4", 2'b00, 2'b01, 16'h1234, 1'b1, 1'b0);
        step();
        chk4("single_k5", 2'b00, 2'b00, 16'h1234, 1'b0, 1'b0);

        // Reset brings rr_ptr back to 0 before the alternation test.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk4("rst_c", 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);

        // Both requesting continuously: 01,10,01,10 every 5 cycles.
        req4  = 2'b11;
        rdat4 = {16'h5555, 16'hAAAA};
        for (int g = 0; g < 4; g++) begin
            logic [1:0]  oh;
            logic [15:0] v;
            oh = (g % 2 == 0) ? 2'b01 : 2'b10;
            v  = (g % 2 == 0) ? 16'hAAAA : 16'h5555;
            step();
            chk4($sformatf("rr%0d_c1", g), oh, 2'b00, v, 1'b1, oh[1]);
            step();
            step();
            chk4($sformatf("rr%0d_c3", g), 2'b00, 2'b00, v, 1'b1, oh[1]);
            step();
            chk4($sformatf("rr%0d_c4", g), 2'b00, oh, v, 1'b1, oh[1]);
            step();
            chk4($sformatf("rr%0d_c5", g), 2'b00, 2'b00, v, 1'b0, oh[1]);
            if (g == 3) req4 = 2'b00;
        end

        // Input changes during a hold are ignored.
        req4  = 2'b01;
        rdat4 = {16'h5555, 16'hBEEF};
        step();
        chk4("hold_c1", 2'b01, 2'b00, 16'hBEEF, 1'b1, 1'b0);
        req4  = 2'b00;
        rdat4 = {16'h0000, 16'hFFFF};
        step();
        chk4("hold_c2", 2'b00, 2'b00, 16'hBEEF, 1'b1, 1'b0);
        req4 = 2'b10;
        step();
        chk4("hold_c3", 2'b00, 2'b00, 16'hBEEF, 1'b1, 1'b0);
        req4 = 2'b00;
        step();
        chk4("hold_c4", 2'b00, 2'b01, 16'hBEEF, 1'b1, 1'b0);
        step();
        chk4("hold_c5", 2'b00, 2'b00, 16'hBEEF, 1'b0, 1'b0);

        // Reset mid-hold: no done, then rr_ptr=0 grants requester 1 for req=10.
        req4  = 2'b01;
        rdat4 = {16'h7E57, 16'hC0DE};
        step();
        chk4("mrst_c1", 2'b01, 2'b00, 16'hC0DE, 1'b1, 1'b0);
        req4 = 2'b00;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk4("mrst_r", 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
        step();
        chk4("mrst_nodone", 2'b00, 2'b00, 16'h0000, 1'b0, 1'b0);
        req4 = 2'b10;
        step();
        chk4("mrst_g1", 2'b10, 2'b00, 16'h7E57, 1'b1, 1'b1);
        req4 = 2'b00;
        step();
        step();
        step();
        chk4("mrst_d1", 2'b00, 2'b10, 16'h7E57, 1'b1, 1'b1);
        step();
        chk4("mrst_i1", 2'b00, 2'b00, 16'h7E57, 1'b0, 1'b1);

        // One-cycle hold: gnt and done coincide, grants every 2 cycles.
        req1  = 2'b11;
        rdat1 = {16'hB0B0, 16'h0A0A};
        step();
        chk1("h1_g0", 2'b01, 2'b01, 16'h0A0A, 1'b1, 1'b0);
        step();
        chk1("h1_i0", 2'b00, 2'b00, 16'h0A0A, 1'b0, 1'b0);
        step();
        chk1("h1_g1", 2'b10, 2'b10, 16'hB0B0, 1'b1, 1'b1);
        step();
        chk1("h1_i1", 2'b00, 2'b00, 16'hB0B0, 1'b0, 1'b1);
        step();
        chk1("h1_g2", 2'b01, 2'b01, 16'h0A0A, 1'b1, 1'b0);
        req1 = 2'b00;
        step();
        step();
        chk1("h1_idle", 2'b00, 2'b00, 16'h0A0A, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
